lcd_bus_monitor: RTL and testbench

//  Receiving end of the HD44780 character-LCD bus driven by lcd/lcd_64bit (LCD_RS, LCD_E, LCD_D).

---
 rtl/lcd_mon_pkg.sv | 35 +++
 rtl/lcd_mon_sync.sv | 64 ++++++
 rtl/lcd_bus_monitor.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_mon_pkg.sv
// Shared types and constants for the HD44780 bus monitor.
// Command classes come from the highest set bit of a command byte.
package lcd_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [3:0] CMD_NONE  = 4'd0;
    localparam logic [3:0] CMD_CLEAR = 4'd1;
    localparam logic [3:0] CMD_HOME  = 4'd2;
    localparam logic [3:0] CMD_ENTRY = 4'd3;
    localparam logic [3:0] CMD_DISP  = 4'd4;
    localparam logic [3:0] CMD_SHIFT = 4'd5;
    localparam logic [3:0] CMD_FUNC  = 4'd6;
    localparam logic [3:0] CMD_CGRAM = 4'd7;
    localparam logic [3:0] CMD_DDRAM = 4'd8;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic logic [3:0] cmd_class(input logic [7:0] d);
        if (d[7])      return CMD_DDRAM;
        else if (d[6]) return CMD_CGRAM;
        else if (d[5]) return CMD_FUNC;
        else if (d[4]) return CMD_SHIFT;
        else if (d[3]) return CMD_DISP;
        else if (d[2]) return CMD_ENTRY;
        else if (d[1]) return CMD_HOME;
        else if (d[0]) return CMD_CLEAR;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/lcd_mon_sync.sv
// Input synchronizers, E-high glitch filter and falling-edge event detect.
// RS/D are captured on every synced-high cycle so the last one is held at the fall.
module lcd_mon_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int E_MIN_HIGH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [7:0] lcd_d,
    output logic       ev_valid,
    output logic       ev_rs,
    output logic [7:0] ev_d
);
    localparam int CW = $clog2(E_MIN_HIGH + 1);

    logic [SYNC_STAGES-1:0] e_sync_q;
    logic [SYNC_STAGES-1:0] rs_sync_q;
    logic [7:0]             d_sync_q [SYNC_STAGES];
    logic [CW-1:0]          hi_cnt_q;
    logic                   rs_hold_q;
    logic [7:0]             d_hold_q;
    logic                   e_s;

    assign e_s = e_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_sync_q  <= '0;
            rs_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
        end else begin
            e_sync_q[0]  <= lcd_e;
            rs_sync_q[0] <= lcd_rs;
            d_sync_q[0]  <= lcd_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                e_sync_q[i]  <= e_sync_q[i-1];
                rs_sync_q[i] <= rs_sync_q[i-1];
                d_sync_q[i]  <= d_sync_q[i-1];
            end
        end
    end

    // Counter saturates at E_MIN_HIGH; it is zero whenever E was low last cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_cnt_q  <= '0;
            rs_hold_q <= 1'b0;
            d_hold_q  <= '0;
        end else if (e_s) begin
            if (hi_cnt_q != CW'(E_MIN_HIGH)) hi_cnt_q <= hi_cnt_q + CW'(1);
            rs_hold_q <= rs_sync_q[SYNC_STAGES-1];
            d_hold_q  <= d_sync_q[SYNC_STAGES-1];
        end else begin
            hi_cnt_q <= '0;
        end
    end

    assign ev_valid = !e_s && (hi_cnt_q == CW'(E_MIN_HIGH));
    assign ev_rs    = rs_hold_q;
    assign ev_d     = d_hold_q;

endmodule

// File: rtl/lcd_bus_monitor.sv
// Passive HD44780 bus monitor rebuilding the visible text into a character buffer.
// Define LCD_MON_4BIT_EN to follow 4-bit interface mode (nibble pairs).
module lcd_bus_monitor #(
    parameter int ROWS        = 2,
    parameter int COLS        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int E_MIN_HIGH  = 4,
    localparam int N          = ROWS * COLS,
    localparam int AW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          lcd_rs,
    input  logic          lcd_e,
    input  logic [7:0]    lcd_d,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] cursor,
    output logic          display_on,
    output logic          cursor_on,
    output logic          blink_on,
    output logic          busy,
    output logic          wr_strobe,
    output logic [15:0]   ev_count,
    output logic          overflow
);
    import lcd_mon_pkg::*;

    logic       ev_valid, ev_rs;
    logic [7:0] ev_d;
    logic       byte_v, byte_rs;
    logic [7:0] byte_d;

    lcd_mon_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .E_MIN_HIGH (E_MIN_HIGH)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .lcd_rs  (lcd_rs),
        .lcd_e   (lcd_e),
        .lcd_d   (lcd_d),
        .ev_valid(ev_valid),
        .ev_rs   (ev_rs),
        .ev_d    (ev_d)
    );

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic [AW-1:0] clr_q, clr_d;
    logic          cur_rs_q, cur_rs_d;
    logic [7:0]    cur_d_q, cur_d_d;
    logic          pend_v_q, pend_v_d;
    logic          pend_rs_q, pend_rs_d;
    logic [7:0]    pend_dat_q, pend_dat_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   evc_q, evc_d;
    logic [AW-1:0] cursor_q, cursor_d;
    logic          id_q, id_d;
    logic          disp_q, disp_d, curs_q, curs_d, blink_q, blink_d;
    logic          cg_q, cg_d, off_q, off_d;
    logic          wrs_q, wrs_d;
    logic [7:0]    rd_q;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    logic [3:0]    cls;
    logic [7:0]    mem [0:N-1];

`ifdef LCD_MON_4BIT_EN
    logic       four_q, four_d, phase_q, phase_d;
    logic [3:0] nib_q, nib_d;
    logic       func_exec;

    assign func_exec = (state_q == EXEC) && !cur_rs_q && (cls == CMD_FUNC);

    // A function set always realigns the nibble phase to the high nibble.
    always_comb begin
        four_d  = four_q;
        phase_d = phase_q;
        nib_d   = nib_q;
        byte_v  = 1'b0;
        byte_rs = ev_rs;
        byte_d  = ev_d;
        if (ev_valid) begin
            if (!four_q) begin
                byte_v = 1'b1;
            end else if (!phase_q) begin
                phase_d = 1'b1;
                nib_d   = ev_d[7:4];
            end else begin
                phase_d = 1'b0;
                byte_v  = 1'b1;
                byte_d  = {nib_q, ev_d[7:4]};
            end
        end
        if (func_exec) begin
            four_d  = !cur_d_q[4];
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            four_q  <= 1'b0;
            phase_q <= 1'b0;
            nib_q   <= '0;
        end else begin
            four_q  <= four_d;
            phase_q <= phase_d;
            nib_q   <= nib_d;
        end
    end
`else
    assign byte_v  = ev_valid;
    assign byte_rs = ev_rs;
    assign byte_d  = ev_d;
`endif

    function automatic logic [AW-1:0] step(input logic [AW-1:0] c, input logic up);
        if (up) return (c == AW'(N - 1)) ? '0 : c + AW'(1);
        return (c == '0) ? AW'(N - 1) : c - AW'(1);
    endfunction

    assign cls = cmd_class(cur_d_q);

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        clr_d      = clr_q;
        cur_rs_d   = cur_rs_q;
        cur_d_d    = cur_d_q;
        pend_v_d   = pend_v_q;
        pend_rs_d  = pend_rs_q;
        pend_dat_d = pend_dat_q;
        ovf_d      = ovf_q;
        evc_d      = evc_q;
        cursor_d   = cursor_q;
        id_d       = id_q;
        disp_d     = disp_q;
        curs_d     = curs_q;
        blink_d    = blink_q;
        cg_d       = cg_q;
        off_d      = off_q;
        wrs_d      = 1'b0;
        we         = 1'b0;
        wa         = cursor_q;
        wd         = cur_d_q;

        if (byte_v) evc_d = evc_q + 16'd1;

        // Idle takes the pending event first; anything else lands in the slot.
        if (state_q == IDLE && !start_q) begin
            if (pend_v_q) begin
                cur_rs_d = pend_rs_q;
                cur_d_d  = pend_dat_q;
                pend_v_d = 1'b0;
                state_d  = EXEC;
            end else if (byte_v) begin
                cur_rs_d = byte_rs;
                cur_d_d  = byte_d;
                state_d  = EXEC;
            end
        end
        if (byte_v && !(state_q == IDLE && !start_q && !pend_v_q)) begin
            if (pend_v_d) begin
                ovf_d = 1'b1;
            end else begin
                pend_v_d   = 1'b1;
                pend_rs_d  = byte_rs;
                pend_dat_d = byte_d;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start_q) begin
                    start_d = 1'b0;
                    state_d = CLEAR;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (cur_rs_q) begin
                    if (!cg_q && !off_q) begin
                        we       = 1'b1;
                        wrs_d    = 1'b1;
                        cursor_d = step(cursor_q, id_q);
                    end
                end else begin
                    unique case (cls)
                        CMD_CLEAR: begin
                            state_d  = CLEAR;
                            cursor_d = '0;
                            id_d     = 1'b1;
                        end
                        CMD_HOME:  cursor_d = '0;
                        CMD_ENTRY: id_d = cur_d_q[1];
                        CMD_DISP: begin
                            disp_d  = cur_d_q[2];
                            curs_d  = cur_d_q[1];
                            blink_d = cur_d_q[0];
                        end
                        CMD_SHIFT: begin
                            if (!cur_d_q[3]) cursor_d = step(cursor_q, cur_d_q[2]);
                        end
                        CMD_CGRAM: cg_d = 1'b1;
                        CMD_DDRAM: begin
                            cg_d = 1'b0;
                            if (32'(cur_d_q[5:0]) >= COLS || 32'(cur_d_q[6]) >= ROWS) begin
                                off_d = 1'b1;
                            end else begin
                                off_d    = 1'b0;
                                cursor_d = AW'(32'(cur_d_q[6]) * COLS + 32'(cur_d_q[5:0]));
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                we = 1'b1;
                wa = clr_q;
                wd = CHAR_SPACE;
                if (clr_q == AW'(N - 1)) begin
                    clr_d   = '0;
                    state_d = IDLE;
                end else begin
                    clr_d = clr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b1;
            clr_q      <= '0;
            cur_rs_q   <= 1'b0;
            cur_d_q    <= '0;
            pend_v_q   <= 1'b0;
            pend_rs_q  <= 1'b0;
            pend_dat_q <= '0;
            ovf_q      <= 1'b0;
            evc_q      <= '0;
            cursor_q   <= '0;
            id_q       <= 1'b1;
            disp_q     <= 1'b0;
            curs_q     <= 1'b0;
            blink_q    <= 1'b0;
            cg_q       <= 1'b0;
            off_q      <= 1'b0;
            wrs_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            clr_q      <= clr_d;
            cur_rs_q   <= cur_rs_d;
            cur_d_q    <= cur_d_d;
            pend_v_q   <= pend_v_d;
            pend_rs_q  <= pend_rs_d;
            pend_dat_q <= pend_dat_d;
            ovf_q      <= ovf_d;
            evc_q      <= evc_d;
            cursor_q   <= cursor_d;
            id_q       <= id_d;
            disp_q     <= disp_d;
            curs_q     <= curs_d;
            blink_q    <= blink_d;
            cg_q       <= cg_d;
            off_q      <= off_d;
            wrs_q      <= wrs_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_q <= '0;
        else       rd_q <= mem[rd_addr];
    end

    assign rd_data    = rd_q;
    assign cursor     = cursor_q;
    assign display_on = disp_q;
    assign cursor_on  = curs_q;
    assign blink_on   = blink_q;
    assign busy       = (state_q == CLEAR);
    assign wr_strobe  = wrs_q;
    assign ev_count   = evc_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor: vector table plus multi-cycle sequences.
// With LCD_MON_4BIT_EN defined it also exercises nibble pairing.
module tb_lcd_bus_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        lcd_rs, lcd_e;
    logic [7:0]  lcd_d;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [4:0]  cursor;
    logic        display_on, cursor_on, blink_on, busy, wr_strobe, overflow;
    logic [15:0] ev_count;

    int total = 0;
    int bad = 0;
    int ws_cnt = 0;
    int busy_cnt = 0;
    int exp_ev = 0;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         a;
        logic [7:0] ed;
        int         ec;
        int         ews;
    } vec_t;

    vec_t tbl [20];

    lcd_bus_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .lcd_rs    (lcd_rs),
        .lcd_e     (lcd_e),
        .lcd_d     (lcd_d),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cursor    (cursor),
        .display_on(display_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .ev_count  (ev_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_strobe) ws_cnt <= ws_cnt + 1;
    always @(posedge clk) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic rs, input logic [7:0] d, input int hi, input int lo);
        lcd_rs = rs;
        lcd_d  = d;
        lcd_e  = 1'b1;
        repeat (hi) @(negedge clk);
        lcd_e = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send(input logic rs, input logic [7:0] d);
        pulse(rs, d, 6, 8);
        exp_ev++;
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        rd_addr = 5'(a);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic chk_spaces(input string nm);
        logic [7:0] v;
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            rd(i, v);
            if (v != 8'h20) n++;
        end
        chk(nm, n, 0);
    endtask

    task automatic wait_busy(input logic want, input int max, input string nm);
        int i = 0;
        while (busy !== want && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(nm, int'(busy), int'(want));
    endtask

    initial begin
        logic [7:0] v;
        int w0, b0, e0;

        tbl[0]  = '{1'b0, 8'h80, -1, 8'h00, 0, 0};
        tbl[1]  = '{1'b1, 8'h48, 0, 8'h48, 1, 1};
        tbl[2]  = '{1'b1, 8'h69, 1, 8'h69, 2, 1};
        tbl[3]  = '{1'b0, 8'hC0, -1, 8'h00, 16, 0};
        tbl[4]  = '{1'b1, 8'h41, 16, 8'h41, 17, 1};
        tbl[5]  = '{1'b0, 8'hCF, -1, 8'h00, 31, 0};
        tbl[6]  = '{1'b1, 8'h42, 31, 8'h42, 0, 1};
        tbl[7]  = '{1'b1, 8'h43, 0, 8'h43, 1, 1};
        tbl[8]  = '{1'b0, 8'h80, -1, 8'h00, 0, 0};
        tbl[9]  = '{1'b0, 8'h04, -1, 8'h00, 0, 0};
        tbl[10] = '{1'b1, 8'h78, 0, 8'h78, 31, 1};
        tbl[11] = '{1'b0, 8'h14, -1, 8'h00, 0, 0};
        tbl[12] = '{1'b0, 8'h10, -1, 8'h00, 31, 0};
        tbl[13] = '{1'b0, 8'h18, -1, 8'h00, 31, 0};
        tbl[14] = '{1'b0, 8'h02, -1, 8'h00, 0, 0};
        tbl[15] = '{1'b0, 8'h06, -1, 8'h00, 0, 0};
        tbl[16] = '{1'b0, 8'hD0, -1, 8'h00, 0, 0};
        tbl[17] = '{1'b1, 8'h7A, 0, 8'h78, 0, 0};
        tbl[18] = '{1'b0, 8'hC5, -1, 8'h00, 21, 0};
        tbl[19] = '{1'b1, 8'h71, 21, 8'h71, 22, 1};

        reset   = 1'b1;
        lcd_rs  = 1'b0;
        lcd_e   = 1'b0;
        lcd_d   = 8'h00;
        rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({display_on, cursor_on, blink_on, wr_strobe, overflow}), 0);
        chk("rst_cnt", int'(ev_count) + int'(cursor) + int'(rd_data), 0);

        reset = 1'b0;
        b0 = busy_cnt;
        repeat (40) @(negedge clk);
        chk("init_busy", int'(busy), 0);
        chk("init_busy_len", busy_cnt - b0, 32);
        chk_spaces("init_spaces");
        chk("init_cursor", int'(cursor), 0);

        for (int i = 0; i < 20; i++) begin
            w0 = ws_cnt;
            send(tbl[i].rs, tbl[i].d);
            chk($sformatf("vec%0d_cursor", i), int'(cursor), tbl[i].ec);
            chk($sformatf("vec%0d_wstrobe", i), ws_cnt - w0, tbl[i].ews);
            if (tbl[i].a >= 0) begin
                rd(tbl[i].a, v);
                chk($sformatf("vec%0d_buf", i), int'(v), int'(tbl[i].ed));
            end
        end
        chk("vec_evcount", int'(ev_count), exp_ev);

        send(1'b0, 8'h04);
        b0 = busy_cnt;
        send(1'b0, 8'h01);
        wait_busy(1'b0, 60, "clr_done");
        chk("clr_busy_len", busy_cnt - b0, 32);
        chk_spaces("clr_spaces");
        chk("clr_cursor", int'(cursor), 0);
        send(1'b1, 8'h61);
        chk("clr_id_inc", int'(cursor), 1);

        e0 = int'(ev_count);
        pulse(1'b1, 8'h55, 2, 8);
        pulse(1'b1, 8'h56, 3, 8);
        chk("short_e_ignored", int'(ev_count), e0);
        chk("short_e_cursor", int'(cursor), 1);

        chk("ovf_before", int'(overflow), 0);
        pulse(1'b0, 8'h01, 6, 0);
        exp_ev++;
        wait_busy(1'b1, 20, "clr2_start");
        pulse(1'b1, 8'h70, 4, 2);
        pulse(1'b1, 8'h71, 4, 2);
        pulse(1'b1, 8'h72, 4, 2);
        exp_ev += 3;
        wait_busy(1'b0, 60, "clr2_done");
        repeat (6) @(negedge clk);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_evcount", int'(ev_count), exp_ev);
        rd(0, v);
        chk("pend_ran", int'(v), 8'h70);
        rd(1, v);
        chk("drop_no_write", int'(v), 8'h20);
        chk("pend_cursor", int'(cursor), 1);

        send(1'b0, 8'h80);
        send(1'b0, 8'h0E);
        chk("disp_0e", int'({display_on, cursor_on, blink_on}), 3'b110);
        send(1'b0, 8'h0D);
        chk("disp_0d", int'({display_on, cursor_on, blink_on}), 3'b101);
        send(1'b0, 8'h40);
        w0 = ws_cnt;
        send(1'b1, 8'h1F);
        chk("cg_wstrobe", ws_cnt - w0, 0);
        rd(0, v);
        chk("cg_buf", int'(v), 8'h70);
        chk("cg_cursor", int'(cursor), 0);
        send(1'b0, 8'h80);
        send(1'b1, 8'h6B);
        rd(0, v);
        chk("dd_after_cg", int'(v), 8'h6B);
        chk("dd_after_cg_cursor", int'(cursor), 1);

`ifdef LCD_MON_4BIT_EN
        send(1'b0, 8'h28);
        pulse(1'b0, 8'h80, 6, 8);
        pulse(1'b0, 8'h00, 6, 8);
        exp_ev++;
        chk("nib_home", int'(cursor), 0);
        e0 = int'(ev_count);
        pulse(1'b1, 8'h40, 6, 8);
        chk("nib_half_nocount", int'(ev_count), e0);
        pulse(1'b1, 8'h10, 6, 8);
        exp_ev++;
        chk("nib_pair_count", int'(ev_count) - e0, 1);
        rd(0, v);
        chk("nib_buf", int'(v), 8'h41);
`endif

        pulse(1'b0, 8'h01, 6, 0);
        wait_busy(1'b1, 20, "clr3_start");
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("midclr_rst_busy", int'(busy), 0);
        chk("midclr_rst_outs", int'({overflow, display_on, blink_on}), 0);
        chk("midclr_rst_cnt", int'(ev_count) + int'(cursor), 0);
        reset = 1'b0;
        b0 = busy_cnt;
        repeat (40) @(negedge clk);
        chk("midclr_rerun_len", busy_cnt - b0, 32);
        chk_spaces("midclr_spaces");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
